// File: rtl/axi4_lib_pkg.sv
// Shared AXI4-Stream helpers: the realigner state encoding and tkeep scan functions.
// Functions take tkeep zero-extended to KEEP_MAX_W bits plus the real lane count, so one
// definition serves every bus width up to KEEP_MAX_W bytes.
package axi4_lib_pkg;

  localparam int KEEP_MAX_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the first beat of a packet
    ST_HOLD  = 2'd1,  // hold register has a non-last beat
    ST_FLUSH = 2'd2   // hold register has the last beat, residue must be drained
  } realign_state_e;

  // Index of the lowest set bit; all-zero keep yields 0.
  function automatic int tkeep_tz(input logic [KEEP_MAX_W-1:0] keep, input int width);
    int tz;
    tz = 0;
    for (int i = KEEP_MAX_W - 1; i >= 0; i--) begin
      if ((i < width) && keep[i]) tz = i;
    end
    return tz;
  endfunction

  // Index of the highest set bit plus one; all-zero keep yields 0.
  function automatic int tkeep_lmo(input logic [KEEP_MAX_W-1:0] keep, input int width);
    int lmo;
    lmo = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if ((i < width) && keep[i]) lmo = i + 1;
    end
    return lmo;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle: tdata/tkeep/tstrb/tlast/tid/tdest/tuser with valid/ready handshake.
// Ports: master drives payload and tvalid, slave drives tready.
// No logic; pure signal grouping.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
) ();

  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tkeep;
  logic [DATA_WIDTH/8-1:0]   tstrb;
  logic                      tlast;
  logic [ID_WIDTH-1:0]       tid;
  logic [DEST_WIDTH-1:0]     tdest;
  logic [USER_WIDTH-1:0]     tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axi4_stream_byte_realign.sv
// Purpose: strip leading null bytes of each packet so byte 0 of beat 0 is the first valid byte.
// Latency: one beat (hold register); output is combinational from hold and the input beat.
// Backpressure: pkt_o.tready=0 freezes hold/state/outputs; input is stalled via pkt_i.tready.
// Ports:
//   clk_i   - clock, all logic on posedge
//   rst_n_i - synchronous active-low reset
//   pkt_i   - input stream (slave), pkt_o - realigned output stream (master)
module axi4_stream_byte_realign
  import axi4_lib_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);

  localparam int DATA_WIDTH_B   = DATA_WIDTH / 8;
  localparam int DATA_WIDTH_B_W = (DATA_WIDTH_B > 1) ? $clog2(DATA_WIDTH_B) : 1;

  // State and hold register
  realign_state_e                r_state;
  realign_state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0]         r_hold_dat;
  logic [DATA_WIDTH_B-1:0]       r_hold_keep;
  logic [DATA_WIDTH_B-1:0]       r_hold_strb;
  logic                          r_hold_last;
  logic [DATA_WIDTH_B_W-1:0]     r_offset;
  logic [ID_WIDTH-1:0]           r_tid;
  logic [DEST_WIDTH-1:0]         r_tdest;
  logic [USER_WIDTH-1:0]         r_tuser;

  // Byte combiner
  logic [DATA_WIDTH-1:0]         w_hold_sh_dat;
  logic [DATA_WIDTH_B-1:0]       w_hold_sh_keep;
  logic [DATA_WIDTH_B-1:0]       w_hold_sh_strb;
  logic [DATA_WIDTH-1:0]         w_in_sh_dat;
  logic [DATA_WIDTH_B-1:0]       w_in_sh_keep;
  logic [DATA_WIDTH_B-1:0]       w_in_sh_strb;
  int                            w_in_lmo;
  logic                          w_absorbed;

  // FSM outputs
  logic                          w_out_vld;
  logic                          w_in_rdy;
  logic [DATA_WIDTH-1:0]         w_out_dat;
  logic [DATA_WIDTH_B-1:0]       w_out_keep;
  logic [DATA_WIDTH_B-1:0]       w_out_strb;
  logic                          w_out_last;
  logic                          w_load_hold;
  logic                          w_first_hs;

  // Hold beat drops its o leading bytes; the incoming beat fills the o freed top lanes.
  // At o=0 the incoming contribution is forced to zero rather than shifted by a full width.
  always_comb begin
    w_hold_sh_dat  = r_hold_dat  >> (8 * int'(r_offset));
    w_hold_sh_keep = r_hold_keep >> int'(r_offset);
    w_hold_sh_strb = r_hold_strb >> int'(r_offset);
    w_in_sh_dat    = '0;
    w_in_sh_keep   = '0;
    w_in_sh_strb   = '0;
    if (r_offset != '0) begin
      w_in_sh_dat  = pkt_i.tdata << (8 * (DATA_WIDTH_B - int'(r_offset)));
      w_in_sh_keep = pkt_i.tkeep << (DATA_WIDTH_B - int'(r_offset));
      w_in_sh_strb = pkt_i.tstrb << (DATA_WIDTH_B - int'(r_offset));
    end
    w_in_lmo   = tkeep_lmo(KEEP_MAX_W'(pkt_i.tkeep), DATA_WIDTH_B);
    // A last beat whose bytes all fit in the freed lanes ends the packet without a flush.
    w_absorbed = pkt_i.tlast && (w_in_lmo <= int'(r_offset));
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_out_vld   = 1'b0;
    w_in_rdy    = 1'b0;
    w_out_dat   = w_hold_sh_dat | w_in_sh_dat;
    w_out_keep  = w_hold_sh_keep | w_in_sh_keep;
    w_out_strb  = w_hold_sh_strb | w_in_sh_strb;
    w_out_last  = 1'b0;
    w_load_hold = 1'b0;
    w_first_hs  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_in_rdy = 1'b1;
        if (pkt_i.tvalid) begin
          w_load_hold = 1'b1;
          w_first_hs  = 1'b1;
          w_state_nxt = pkt_i.tlast ? ST_FLUSH : ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Output valid follows input valid only, never the downstream ready.
        w_out_vld  = pkt_i.tvalid;
        w_in_rdy   = pkt_o.tready;
        w_out_last = w_absorbed;
        if (pkt_i.tvalid && pkt_o.tready) begin
          if (w_absorbed) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_load_hold = 1'b1;
            w_state_nxt = pkt_i.tlast ? ST_FLUSH : ST_HOLD;
          end
        end
      end

      ST_FLUSH: begin
        w_out_vld  = 1'b1;
        w_out_dat  = w_hold_sh_dat;
        w_out_keep = w_hold_sh_keep;
        w_out_strb = w_hold_sh_strb;
        w_out_last = 1'b1;
        if (pkt_o.tready) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_hold_dat  <= '0;
      r_hold_keep <= '0;
      r_hold_strb <= '0;
      r_hold_last <= 1'b0;
      r_offset    <= '0;
      r_tid       <= '0;
      r_tdest     <= '0;
      r_tuser     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_hold) begin
        r_hold_dat  <= pkt_i.tdata;
        r_hold_keep <= pkt_i.tkeep;
        r_hold_strb <= pkt_i.tstrb;
        r_hold_last <= pkt_i.tlast;
      end
      // Offset and sideband are locked on the first beat for the whole packet.
      if (w_first_hs) begin
        r_offset <= DATA_WIDTH_B_W'(tkeep_tz(KEEP_MAX_W'(pkt_i.tkeep), DATA_WIDTH_B));
        r_tid    <= pkt_i.tid;
        r_tdest  <= pkt_i.tdest;
        r_tuser  <= pkt_i.tuser;
      end
    end
  end

  assign pkt_i.tready = w_in_rdy;
  assign pkt_o.tvalid = w_out_vld;
  assign pkt_o.tdata  = w_out_dat;
  assign pkt_o.tkeep  = w_out_keep;
  assign pkt_o.tstrb  = w_out_strb;
  assign pkt_o.tlast  = w_out_last;
  assign pkt_o.tid    = r_tid;
  assign pkt_o.tdest  = r_tdest;
  assign pkt_o.tuser  = r_tuser;

  // r_hold_last mirrors the FLUSH state; kept for visibility of the held beat.
  logic w_unused;
  assign w_unused = r_hold_last;

endmodule
